// File: rtl/arbitro_escrita_regs_if.sv
// arbitro_escrita_regs_if
// Bundle of the request and write-port signals between the three
// register-file writers and the write-port arbiter.
//
// Handshake: a requester asserts valid[i] with a stable payload and holds both
// until a rising clock edge where valid[i] && ready[i]. That edge is the accept
// edge, and the payload is sampled only on it. ready[i] never depends on valid.
//
// Signals:
//   valid[2:0]        request valid: [0] ALU, [1] memory, [2] mult/div
//   ready[2:0]        arbiter can take request i on the next edge
//   end_alu/dados_alu ALU destination register and data
//   end_mem/dados_mem load destination register and data
//   dados_md          mult/div result, [63:32] -> HI (63), [31:0] -> LO (62)
//   writeRegs         write strobe to the register file
//   hilo              1 = 64-bit HI/LO write, 0 = 32-bit write
//   endereco_escrita  32-bit write address (63 on HI/LO writes)
//   dados_escrita_32  32-bit write data
//   dados_escrita_64  64-bit HI/LO write data
//   ocupado           any holding buffer full
//   dbg_full/dbg_ptr  observation of buffer flags and round-robin pointer
// Modports: master = requester/register-file side, slave = arbiter.
interface arbitro_escrita_regs_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [2:0]          valid;
  logic [2:0]          ready;
  logic [ADDR_W-1:0]   end_alu;
  logic [DATA_W-1:0]   dados_alu;
  logic [ADDR_W-1:0]   end_mem;
  logic [DATA_W-1:0]   dados_mem;
  logic [2*DATA_W-1:0] dados_md;
  logic                writeRegs;
  logic                hilo;
  logic [ADDR_W-1:0]   endereco_escrita;
  logic [DATA_W-1:0]   dados_escrita_32;
  logic [2*DATA_W-1:0] dados_escrita_64;
  logic                ocupado;
  logic [2:0]          dbg_full;
  logic [1:0]          dbg_ptr;

  modport master (
    output valid, end_alu, dados_alu, end_mem, dados_mem, dados_md,
    input  ready, writeRegs, hilo, endereco_escrita, dados_escrita_32,
           dados_escrita_64, ocupado, dbg_full, dbg_ptr
  );

  modport slave (
    input  valid, end_alu, dados_alu, end_mem, dados_mem, dados_md,
    output ready, writeRegs, hilo, endereco_escrita, dados_escrita_32,
           dados_escrita_64, ocupado, dbg_full, dbg_ptr
  );
endinterface

// File: rtl/arbitro_escrita_regs.sv
// arbitro_escrita_regs
// Write-port arbiter for the 64x32 register file. ALU, load and mult/div
// writebacks each own a one-entry holding buffer; a round-robin scheduler
// issues at most one buffered write per cycle into registered outputs, which
// the register file captures on the following negedge.
//
// Ports:
//   clock  system clock, all state updates on posedge
//   reset  asynchronous, active-low
//   bus    arbitro_escrita_regs_if.slave (requests in, write port out)
//
// Option: define ARB_HILO_PRIO_EN to let mult/div win whenever its buffer is
// full; the pointer then advances only on ALU/memory issues.
module arbitro_escrita_regs #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input logic                  clock,
  input logic                  reset,
  arbitro_escrita_regs_if.slave bus
);

  localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(63);

  // Holding buffers
  logic [2:0]          full;
  logic [ADDR_W-1:0]   addr_alu;
  logic [DATA_W-1:0]   data_alu;
  logic [ADDR_W-1:0]   addr_mem;
  logic [DATA_W-1:0]   data_mem;
  logic [2*DATA_W-1:0] data_md;

  // Round-robin pointer, always 0..2
  logic [1:0] ptr;

  // Registered write port
  logic                write_q;
  logic                hilo_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data32_q;
  logic [2*DATA_W-1:0] data64_q;

  // Scheduling
  logic [2:0] rr_grant;
  logic [1:0] rr_winner;
  logic       rr_any;
  logic [2:0] grant;
  logic [1:0] winner;
  logic       any_grant;
  logic [1:0] ptr_next;
  logic [2:0] accept;

  // Round-robin search: ptr, ptr+1, ptr+2 (mod 3); first full buffer wins.
  // Depends only on full and ptr, so ready has no path from valid.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] idx;
    rr_grant  = 3'b000;
    rr_winner = 2'd0;
    rr_any    = 1'b0;
    sum       = 3'd0;
    idx       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!rr_any && full[idx]) begin
        rr_any        = 1'b1;
        rr_winner     = idx;
        rr_grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    grant     = rr_grant;
    winner    = rr_winner;
    any_grant = rr_any;
`ifdef ARB_HILO_PRIO_EN
    if (full[2]) begin
      grant     = 3'b100;
      winner    = 2'd2;
      any_grant = 1'b1;
    end
`endif
  end

  assign ptr_next = (winner == 2'd2) ? 2'd0 : winner + 2'd1;

  // A buffer being issued this cycle can be refilled on the same edge.
  assign bus.ready = ~full | grant;
  assign accept    = bus.valid & bus.ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full     <= 3'b000;
      addr_alu <= '0;
      data_alu <= '0;
      addr_mem <= '0;
      data_mem <= '0;
      data_md  <= '0;
    end else begin
      // Reload wins over the clear of an issued buffer.
      full <= accept | (full & ~grant);
      if (accept[0]) begin
        addr_alu <= bus.end_alu;
        data_alu <= bus.dados_alu;
      end
      if (accept[1]) begin
        addr_mem <= bus.end_mem;
        data_mem <= bus.dados_mem;
      end
      if (accept[2]) begin
        data_md <= bus.dados_md;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr      <= 2'd0;
      write_q  <= 1'b0;
      hilo_q   <= 1'b0;
      addr_q   <= '0;
      data32_q <= '0;
      data64_q <= '0;
    end else begin
      write_q <= any_grant;
      hilo_q  <= any_grant && grant[2];
      if (any_grant) begin
        case (winner)
          2'd0: begin
            addr_q   <= addr_alu;
            data32_q <= data_alu;
          end
          2'd1: begin
            addr_q   <= addr_mem;
            data32_q <= data_mem;
          end
          default: begin
            // HI/LO pair is written as one 64-bit value; the 32-bit data
            // register keeps its previous content.
            addr_q   <= HI_ADDR;
            data64_q <= data_md;
          end
        endcase
`ifdef ARB_HILO_PRIO_EN
        if (winner != 2'd2) ptr <= ptr_next;
`else
        ptr <= ptr_next;
`endif
      end
    end
  end

  assign bus.writeRegs        = write_q;
  assign bus.hilo             = hilo_q;
  assign bus.endereco_escrita = addr_q;
  assign bus.dados_escrita_32 = data32_q;
  assign bus.dados_escrita_64 = data64_q;
  assign bus.ocupado          = |full;
  assign bus.dbg_full         = full;
  assign bus.dbg_ptr          = ptr;

endmodule
